// File: rtl/piso_pkg.sv
// piso_pkg: shared types and helpers for the parallel-in/serial-out shifter.
//   piso_state_t : controller state (idle / shifting)
//   cnt_width()  : bit width needed to hold a count from 0 to WIDTH inclusive
package piso_pkg;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } piso_state_t;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/piso_shifter_bit_counter.sv
// bit_counter: down-counter with synchronous active-low reset, parallel load
// and enable. It saturates at zero rather than wrapping.
//   clk    : clock
//   rst    : synchronous reset, active-low
//   ld     : load ld_val (takes priority over en)
//   en     : decrement when nonzero
//   ld_val : value to load
//   zero   : count is zero
module bit_counter
  import piso_pkg::*;
#(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld,
  input  logic          en,
  input  logic [CW-1:0] ld_val,
  output logic          zero
);

  logic [CW-1:0] cnt_d;
  logic [CW-1:0] cnt_q;

  // Next count: load wins, otherwise decrement without passing below zero.
  always_comb begin
    cnt_d = cnt_q;
    if (ld) begin
      cnt_d = ld_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1'b1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/piso_shifter.sv
// piso_shifter: serializes a WIDTH-bit word, accepted through a valid/ready
// handshake, onto a registered 1-bit output plus its complement.
//   clk        : clock
//   rst        : synchronous reset, active-low
//   en         : shift enable (does not gate loading)
//   load_valid : load_data is valid
//   load_ready : idle, a word can be accepted
//   load_data  : word to serialize
//   sout/soutn : current serial bit and its complement (registered)
//   busy       : shifting a word
//   done       : one-cycle pulse after the final bit has been presented
module piso_shifter
  import piso_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             sout,
  output logic             soutn,
  output logic             busy,
  output logic             done
);

  localparam int CW = cnt_width(WIDTH);

  piso_state_t      state_d, state_q;
  logic [WIDTH-1:0] sreg_d, sreg_q;
  logic             sout_d, sout_q;
  logic             soutn_d, soutn_q;
  logic             done_d, done_q;
  logic             cnt_ld;
  logic             cnt_en;
  logic             cnt_zero;

  // Bit that leaves the word first in the configured order.
  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  // Word with the first-out bit removed, remaining bits moved toward the exit.
  function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? (w << 1'b1) : (w >> 1'b1);
  endfunction

  // The counter holds the number of bits still to present after the current one.
  bit_counter #(
    .CW(CW)
  ) u_count (
    .clk   (clk),
    .rst   (rst),
    .ld    (cnt_ld),
    .en    (cnt_en),
    .ld_val(CW'(WIDTH - 1)),
    .zero  (cnt_zero)
  );

  // Next-state, next-data and done pulse generation.
  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    sout_d  = sout_q;
    done_d  = 1'b0;
    cnt_ld  = 1'b0;
    cnt_en  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (load_valid) begin
          sout_d  = first_bit(load_data);
          sreg_d  = shift_word(load_data);
          cnt_ld  = 1'b1;
          state_d = S_SHIFT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (en) begin
          if (!cnt_zero) begin
            sout_d = first_bit(sreg_q);
            sreg_d = shift_word(sreg_q);
            cnt_en = 1'b1;
          end else begin
            // Final bit has had its enabled cycle; sout keeps showing it.
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end else begin
          state_d = S_SHIFT;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    soutn_d = ~sout_d;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      sreg_q  <= '0;
      sout_q  <= 1'b0;
      soutn_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      sout_q  <= sout_d;
      soutn_q <= soutn_d;
      done_q  <= done_d;
    end
  end

  assign load_ready = (state_q == S_IDLE);
  assign busy       = (state_q == S_SHIFT);
  assign sout       = sout_q;
  assign soutn      = soutn_q;
  assign done       = done_q;

endmodule

// File: tb/tb_piso_shifter.sv
// Bench for piso_shifter: three instances (8-bit MSB-first, 8-bit LSB-first,
// 1-bit) against a word/index reference model, plus a constant-expectation
// vector table and directed corner sequences.
module tb_piso_shifter;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [2:0] lv;
  logic [7:0] data_a;
  logic [7:0] data_b;
  logic [0:0] data_c;
  logic [2:0] ready_w, sout_w, soutn_w, busy_w, done_w;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  piso_shifter #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_a (
    .clk(clk), .rst(rst), .en(en), .load_valid(lv[0]), .load_ready(ready_w[0]),
    .load_data(data_a), .sout(sout_w[0]), .soutn(soutn_w[0]), .busy(busy_w[0]), .done(done_w[0]));

  piso_shifter #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_b (
    .clk(clk), .rst(rst), .en(en), .load_valid(lv[1]), .load_ready(ready_w[1]),
    .load_data(data_b), .sout(sout_w[1]), .soutn(soutn_w[1]), .busy(busy_w[1]), .done(done_w[1]));

  piso_shifter #(.WIDTH(1), .MSB_FIRST(1'b1)) dut_c (
    .clk(clk), .rst(rst), .en(en), .load_valid(lv[2]), .load_ready(ready_w[2]),
    .load_data(data_c), .sout(sout_w[2]), .soutn(soutn_w[2]), .busy(busy_w[2]), .done(done_w[2]));

  // Reference model: the captured word and the emission index of the bit on sout.
  int         m_width[3] = '{8, 8, 1};
  bit         m_msb[3]   = '{1'b1, 1'b0, 1'b1};
  logic [7:0] m_word[3];
  int         m_k[3];
  bit         m_busy[3];
  bit         m_cur[3];
  bit         m_done[3];

  function automatic bit bit_at(input logic [7:0] w, input int k, input int width, input bit msb);
    return msb ? w[width - 1 - k] : w[k];
  endfunction

  function automatic logic [7:0] word_of(input int i);
    if (i == 0) return data_a;
    if (i == 1) return data_b;
    return {7'd0, data_c};
  endfunction

  task automatic model_edge();
    for (int i = 0; i < 3; i++) begin
      if (!rst) begin
        m_busy[i] = 1'b0; m_cur[i] = 1'b0; m_done[i] = 1'b0; m_k[i] = 0; m_word[i] = 8'd0;
      end else begin
        m_done[i] = 1'b0;
        if (!m_busy[i]) begin
          if (lv[i]) begin
            m_word[i] = word_of(i);
            m_k[i]    = 0;
            m_busy[i] = 1'b1;
            m_cur[i]  = bit_at(m_word[i], 0, m_width[i], m_msb[i]);
          end
        end else if (en) begin
          if (m_k[i] < m_width[i] - 1) begin
            m_k[i]   = m_k[i] + 1;
            m_cur[i] = bit_at(m_word[i], m_k[i], m_width[i], m_msb[i]);
          end else begin
            m_busy[i] = 1'b0;
            m_done[i] = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic check(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%b want=%b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("sout[%0d]", i),  sout_w[i],  m_cur[i]);
      check($sformatf("soutn[%0d]", i), soutn_w[i], ~m_cur[i]);
      check($sformatf("busy[%0d]", i),  busy_w[i],  m_busy[i]);
      check($sformatf("ready[%0d]", i), ready_w[i], ~m_busy[i]);
      check($sformatf("done[%0d]", i),  done_w[i],  m_done[i]);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  typedef struct {
    logic       rst, en, lv;
    logic [7:0] data;
    logic       e_sout, e_busy, e_done, e_ready;
  } vec_t;

  vec_t       tbl[11];
  logic [10:0] stall_pat;

  initial begin
    // 0xA5 MSB-first on instance a, then a reset with load_valid held.
    tbl[0]  = '{1'b1, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1};

    // Reset for two cycles with random other inputs.
    rst = 1'b0; lv = 3'(urand3()); en = 1'($urandom);
    data_a = 8'($urandom); data_b = 8'($urandom); data_c = 1'($urandom);
    for (int c = 0; c < 2; c++) begin
      cycle();
      for (int i = 0; i < 3; i++) begin
        check($sformatf("rst_sout[%0d]", i),  sout_w[i],  1'b0);
        check($sformatf("rst_soutn[%0d]", i), soutn_w[i], 1'b1);
        check($sformatf("rst_busy[%0d]", i),  busy_w[i],  1'b0);
        check($sformatf("rst_done[%0d]", i),  done_w[i],  1'b0);
        check($sformatf("rst_ready[%0d]", i), ready_w[i], 1'b1);
      end
      lv = 3'(urand3()); en = 1'($urandom);
    end
    rst = 1'b1; lv = 3'b000; en = 1'b1;
    cycle();

    // Vector table on instance a.
    for (int v = 0; v < 11; v++) begin
      rst = tbl[v].rst; en = tbl[v].en; lv = {2'b00, tbl[v].lv}; data_a = tbl[v].data;
      cycle();
      check($sformatf("tbl%0d_sout", v),  sout_w[0],  tbl[v].e_sout);
      check($sformatf("tbl%0d_soutn", v), soutn_w[0], ~tbl[v].e_sout);
      check($sformatf("tbl%0d_busy", v),  busy_w[0],  tbl[v].e_busy);
      check($sformatf("tbl%0d_done", v),  done_w[0],  tbl[v].e_done);
      check($sformatf("tbl%0d_ready", v), ready_w[0], tbl[v].e_ready);
    end
    rst = 1'b1; lv = 3'b000; en = 1'b1;
    cycle();

    // Stall: load 0xA5 then an enable pattern with eight enabled edges.
    stall_pat = 11'b11111011001;
    lv = 3'b001; data_a = 8'hA5;
    cycle();
    lv = 3'b000;
    for (int j = 0; j < 11; j++) begin
      en = stall_pat[j];
      check("stall_not_done_early", done_w[0], 1'b0);
      cycle();
    end
    check("stall_done", done_w[0], 1'b1);
    en = 1'b1;
    cycle();

    // Load request while busy is ignored; taken on the first ready edge.
    lv = 3'b001; data_a = 8'hA5;
    cycle();
    lv = 3'b000;
    for (int j = 0; j < 3; j++) cycle();
    lv = 3'b001; data_a = 8'hFF;
    for (int j = 0; j < 4; j++) cycle();
    cycle();
    check("busyload_done", done_w[0], 1'b1);
    check("busyload_ready", ready_w[0], 1'b1);
    cycle();
    check("busyload_taken", busy_w[0], 1'b1);
    check("busyload_bit0", sout_w[0], 1'b1);
    lv = 3'b000;
    for (int j = 0; j < 9; j++) cycle();

    // Reset mid-shift of 0x3C, then 0x81.
    lv = 3'b001; data_a = 8'h3C;
    cycle();
    lv = 3'b000;
    for (int j = 0; j < 2; j++) cycle();
    rst = 1'b0;
    cycle();
    check("midrst_sout", sout_w[0], 1'b0);
    check("midrst_busy", busy_w[0], 1'b0);
    check("midrst_ready", ready_w[0], 1'b1);
    rst = 1'b1;
    cycle();
    check("midrst_nodone", done_w[0], 1'b0);
    lv = 3'b001; data_a = 8'h81;
    cycle();
    lv = 3'b000;
    for (int j = 0; j < 9; j++) cycle();

    // LSB-first 0x01 on instance b.
    lv = 3'b010; data_b = 8'h01;
    cycle();
    check("lsb_bit0", sout_w[1], 1'b1);
    lv = 3'b000;
    for (int j = 1; j < 8; j++) begin
      cycle();
      check($sformatf("lsb_bit%0d", j), sout_w[1], 1'b0);
    end
    cycle();
    check("lsb_done", done_w[1], 1'b1);

    // WIDTH=1 on instance c.
    lv = 3'b100; data_c = 1'b1;
    cycle();
    check("w1_sout", sout_w[2], 1'b1);
    check("w1_busy", busy_w[2], 1'b1);
    lv = 3'b000;
    cycle();
    check("w1_idle", busy_w[2], 1'b0);
    check("w1_done", done_w[2], 1'b1);
    cycle();

    // Random traffic on all instances against the model.
    for (int n = 0; n < 600; n++) begin
      rst    = ($urandom_range(0, 39) != 0);
      en     = ($urandom_range(0, 3) != 0);
      lv     = 3'(urand3());
      data_a = 8'($urandom);
      data_b = 8'($urandom);
      data_c = 1'($urandom);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  function automatic int unsigned urand3();
    return $urandom_range(0, 7);
  endfunction

endmodule
